// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers ALU results in a 2-entry FIFO and writes them
// to the register file through a valid/ready handshake. Signed-overflow
// results of ADD/SUB can raise a trap that blocks further accepts until
// acknowledged, while already-buffered results keep draining.
module alu_writeback #(
   parameter bit TRAP_EN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   // ALU result side
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_result,
   input  logic        in_overflow,
   input  logic        in_zero,
   input  logic        in_negative,
   input  logic [2:0]  in_control,
   input  logic [4:0]  in_rd,
   // Register-file write side
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [31:0] wr_data,
   output logic [4:0]  wr_num,
   // Status
   output logic [2:0]  flags,
   output logic        trap,
   output logic [4:0]  trap_rd,
   input  logic        trap_ack,
   output logic [15:0] commit_count
);

   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] fifo_data [2];
   logic [4:0]  fifo_rd   [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic accept;
   logic is_arith;
   logic is_trap;
   logic push;
   logic pop;

   // Acceptance never looks at wr_ready, so there is no combinational path
   // from the register-file side back to the ALU side.
   assign in_ready = (count != 2'd2) && (state == RUN);
   assign accept   = in_valid && in_ready;

   // Register 0 is hard-wired, so rd==0 accepts are dropped before any trap
   // decision; only ADD/SUB overflow is meaningful.
   assign is_arith = (in_control == OP_ADD) || (in_control == OP_SUB);
   assign is_trap  = TRAP_EN && is_arith && in_overflow && (in_rd != 5'd0);
   assign push     = accept && (in_rd != 5'd0) && !is_trap;
   assign pop      = (count != 2'd0) && wr_ready;

   assign wr_valid = (count != 2'd0);
   assign wr_data  = fifo_data[rd_ptr];
   assign wr_num   = fifo_rd[rd_ptr];
   assign trap     = (state == TRAP);

   // FIFO storage: write the accepted entry at the tail.
   // NOTE: storage is deliberately not reset; emptiness is defined by count,
   // so stale contents are never presented as valid.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data[wr_ptr] <= in_result;
         fifo_rd[wr_ptr]   <= in_rd;
      end
   end

   // FIFO pointers, occupancy and completed-write counter.
   // NOTE: non-blocking assignments keep every register sampling pre-edge
   // values, so push and pop in the same cycle see a consistent count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
         commit_count <= 16'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr       <= ~rd_ptr;
            commit_count <= commit_count + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // RUN/TRAP state machine with registered flags and trap register number.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= RUN;
         flags   <= 3'b000;
         trap_rd <= 5'd0;
      end else begin
         if (accept) flags <= {in_overflow, in_negative, in_zero};
         case (state)
            RUN: begin
               if (accept && is_trap) begin
                  state   <= TRAP;
                  trap_rd <= in_rd;
               end
            end
            TRAP: begin
               if (trap_ack) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (TRAP_EN = 1).
module tb_alu_writeback;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic        in_overflow;
   logic        in_zero;
   logic        in_negative;
   logic [2:0]  in_control;
   logic [4:0]  in_rd;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic [4:0]  wr_num;
   logic [2:0]  flags;
   logic        trap;
   logic [4:0]  trap_rd;
   logic        trap_ack;
   logic [15:0] commit_count;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_commit;

   always #5 clock = ~clock;

   alu_writeback #(.TRAP_EN(1'b1)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_overflow  (in_overflow),
      .in_zero      (in_zero),
      .in_negative  (in_negative),
      .in_control   (in_control),
      .in_rd        (in_rd),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .wr_num       (wr_num),
      .flags        (flags),
      .trap         (trap),
      .trap_rd      (trap_rd),
      .trap_ack     (trap_ack),
      .commit_count (commit_count)
   );

   typedef struct {
      logic        v;
      logic [31:0] res;
      logic        ovf;
      logic        zero;
      logic        neg;
      logic [2:0]  ctrl;
      logic [4:0]  rd;
      logic        wrr;
      logic        e_wv;
      logic [31:0] e_data;
      logic [4:0]  e_num;
      logic [2:0]  e_flags;
      logic [15:0] e_commit;
      logic        e_trap;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else
         n_pass++;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic ovf,
                        input logic zero, input logic neg, input logic [2:0] ctrl,
                        input logic [4:0] rd);
      in_valid    = v;
      in_result   = res;
      in_overflow = ovf;
      in_zero     = zero;
      in_negative = neg;
      in_control  = ctrl;
      in_rd       = rd;
   endtask

   vec_t vecs [8];

   initial begin
      // {v, res, ovf, zero, neg, ctrl, rd, wr_ready, exp wr_valid, exp data, exp num, exp flags, exp commit, exp trap}
      vecs[0] = '{1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 3'd2,  5'd3, 1'b1, 1'b1, 32'h0000_0005,  5'd3, 3'b000, 16'd0, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3'd2,  5'd0, 1'b1, 1'b0, 32'h0000_0000,  5'd0, 3'b000, 16'd1, 1'b0};
      vecs[2] = '{1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 3'd7,  5'd4, 1'b1, 1'b1, 32'h8000_0000,  5'd4, 3'b110, 16'd1, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 3'd4,  5'd0, 1'b1, 1'b0, 32'h0000_0000,  5'd0, 3'b001, 16'd2, 1'b0};
      vecs[4] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 3'd5, 5'd31, 1'b0, 1'b1, 32'h1234_5678, 5'd31, 3'b000, 16'd2, 1'b0};
      vecs[5] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3'd5,  5'd0, 1'b0, 1'b1, 32'h1234_5678, 5'd31, 3'b000, 16'd2, 1'b0};
      vecs[6] = '{1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1, 3'd6,  5'd9, 1'b1, 1'b1, 32'hFFFF_0000,  5'd9, 3'b010, 16'd3, 1'b0};
      vecs[7] = '{1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 3'd2,  5'd0, 1'b1, 1'b0, 32'h0000_0000,  5'd0, 3'b100, 16'd4, 1'b0};

      reset    = 1'b1;
      wr_ready = 1'b0;
      trap_ack = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      step();
      step();
      reset = 1'b0;
      #1;

      // Reset state
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_trap", 32'(trap), 32'd0);
      check("rst_trap_rd", 32'(trap_rd), 32'd0);
      check("rst_commit", 32'(commit_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Table: basic writes, hold-while-stalled, push+pop, rd==0 and XOR overflow
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].v, vecs[i].res, vecs[i].ovf, vecs[i].zero, vecs[i].neg, vecs[i].ctrl, vecs[i].rd);
         wr_ready = vecs[i].wrr;
         step();
         check($sformatf("vec%0d_wr_valid", i), 32'(wr_valid), 32'(vecs[i].e_wv));
         if (vecs[i].e_wv) begin
            check($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].e_data);
            check($sformatf("vec%0d_wr_num", i), 32'(wr_num), 32'(vecs[i].e_num));
         end
         check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].e_flags));
         check($sformatf("vec%0d_commit", i), 32'(commit_count), 32'(vecs[i].e_commit));
         check($sformatf("vec%0d_trap", i), 32'(trap), 32'(vecs[i].e_trap));
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      end
      exp_commit = 4;

      // Back-pressure: fill, stall the third, drain in order
      drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 3'd2, 5'd1);
      wr_ready = 1'b0;
      step();
      check("bp_in_ready_1", 32'(in_ready), 32'd1);
      drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 3'd2, 5'd2);
      step();
      check("bp_in_ready_full", 32'(in_ready), 32'd0);
      check("bp_head_num", 32'(wr_num), 32'd1);
      drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 3'd2, 5'd3);
      step();
      check("bp_still_full", 32'(in_ready), 32'd0);
      check("bp_head_held", wr_data, 32'h11);
      wr_ready = 1'b1;
      step();
      check("bp_pop1_num", 32'(wr_num), 32'd2);
      check("bp_pop1_data", wr_data, 32'h22);
      check("bp_space_freed", 32'(in_ready), 32'd1);
      step();
      check("bp_pop2_num", 32'(wr_num), 32'd3);
      check("bp_pop2_data", wr_data, 32'h33);
      in_valid = 1'b0;
      step();
      exp_commit += 3;
      check("bp_drained", 32'(wr_valid), 32'd0);
      check("bp_commit", 32'(commit_count), 32'(exp_commit));

      // Trap: buffered entry drains during TRAP, accepts blocked until ack
      wr_ready = 1'b0;
      drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 3'd2, 5'd5);
      step();
      drive(1'b1, 32'h8000_0001, 1'b1, 1'b0, 1'b1, 3'd3, 5'd7);
      step();
      check("trap_set", 32'(trap), 32'd1);
      check("trap_rd", 32'(trap_rd), 32'd7);
      check("trap_in_ready", 32'(in_ready), 32'd0);
      check("trap_flags", 32'(flags), 32'b110);
      check("trap_head_num", 32'(wr_num), 32'd5);
      drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 3'd2, 5'd8);
      wr_ready = 1'b1;
      step();
      exp_commit += 1;
      check("trap_drain_commit", 32'(commit_count), 32'(exp_commit));
      check("trap_no_write", 32'(wr_valid), 32'd0);
      check("trap_held", 32'(trap), 32'd1);
      in_valid = 1'b0;
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      check("trap_cleared", 32'(trap), 32'd0);
      check("trap_ack_in_ready", 32'(in_ready), 32'd1);
      check("trap_no_late_write", 32'(wr_valid), 32'd0);
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      check("ack_in_run_trap", 32'(trap), 32'd0);
      check("ack_in_run_ready", 32'(in_ready), 32'd1);

      // commit_count wrap: bring it to 0xFFFF, then one more write
      drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd1);
      wr_ready = 1'b1;
      for (int i = 0; i < 65535 - exp_commit; i++) step();
      in_valid = 1'b0;
      step();
      check("wrap_preset", 32'(commit_count), 32'h0000_FFFF);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("wrap_zero", 32'(commit_count), 32'h0000_0000);
      check("wrap_empty", 32'(wr_valid), 32'd0);

      // Mid-operation reset with a buffered entry and a pending trap
      wr_ready = 1'b0;
      drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 3'd4, 5'd10);
      step();
      drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 3'd2, 5'd12);
      step();
      in_valid = 1'b0;
      check("pre_rst_trap", 32'(trap), 32'd1);
      check("pre_rst_wr_valid", 32'(wr_valid), 32'd1);
      wr_ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_wr_valid", 32'(wr_valid), 32'd0);
      check("async_rst_trap", 32'(trap), 32'd0);
      check("async_rst_trap_rd", 32'(trap_rd), 32'd0);
      check("async_rst_flags", 32'(flags), 32'd0);
      check("async_rst_commit", 32'(commit_count), 32'd0);
      step();
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      step();
      check("post_rst_no_write", 32'(commit_count), 32'd0);
      check("post_rst_empty", 32'(wr_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
